// File: rtl/control_pipe.sv
// control_pipe: RV32I control decoder for the ID stage plus registered
// ID/EX, EX/MEM and MEM/WB control stages. Each stage has a valid bit.
// The block handles stall, flush and load-use hazard detection.
//
// Optional feature macro: CONTROL_PIPE_ILLEGAL_EN adds ex_illegal_o.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   instruction_i, id_valid_i  instruction in ID and its valid bit
//   stall_i, flush_i         global freeze, kill of the ID instruction
//   hazard_stall_o           combinational load-use stall request
//   ex_*                     ID/EX control stage
//   mem_*                    EX/MEM control stage
//   wb_*                     MEM/WB control stage
//   ex_illegal_o             illegal-instruction flag (macro only)
module control_pipe #(
  parameter int unsigned ALU_OP_W   = 6,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           instruction_i,
  input  logic                  id_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  hazard_stall_o,
  output logic                  ex_valid_o,
  output logic                  ex_alusrc1_o,
  output logic                  ex_alusrc2_o,
  output logic [ALU_OP_W-1:0]   ex_alu_op_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic [2:0]            ex_funct3_o,
  output logic                  mem_valid_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [2:0]            mem_funct3_o,
  output logic                  wb_valid_o,
  output logic                  wb_reg_write_o,
  output logic [1:0]            wb_dmem_to_reg_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o
`ifdef CONTROL_PIPE_ILLEGAL_EN
  ,
  output logic                  ex_illegal_o
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SUB  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd15;

  typedef struct packed {
    logic                  alusrc1;
    logic                  alusrc2;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  branch;
    logic                  jump;
    logic [2:0]            funct3;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            dmem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
`ifdef CONTROL_PIPE_ILLEGAL_EN
    logic                  illegal;
`endif
  } ex_ctrl_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic                  reg_write;
    logic [1:0]            dmem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            dmem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  dec_c;
  logic      use_rs1_c;
  logic      use_rs2_c;
  logic      illegal_c;
  logic      hazard_c;

  ex_ctrl_t  ex_q, ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q, wb_d;
  logic      ex_valid_q, ex_valid_d;
  logic      mem_valid_q, mem_valid_d;
  logic      wb_valid_q, wb_valid_d;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  bad_funct7;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;

  assign opcode     = instruction_i[6:0];
  assign funct3     = instruction_i[14:12];
  assign funct7     = instruction_i[31:25];
  assign bad_funct7 = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
  assign rs1        = REG_ADDR_W'(instruction_i[19:15]);
  assign rs2        = REG_ADDR_W'(instruction_i[24:20]);

  // Instruction decode for the ID stage
  always_comb begin
    dec_c        = '0;
    dec_c.alu_op = ALU_OP_W'(ALU_PASS);
    use_rs1_c    = 1'b0;
    use_rs2_c    = 1'b0;
    illegal_c    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_c.reg_write   = 1'b1;
        dec_c.dmem_to_reg = 2'b11;
      end
      OPC_AUIPC: begin
        dec_c.alusrc1     = 1'b1;
        dec_c.alusrc2     = 1'b1;
        dec_c.alu_op      = ALU_OP_W'(ALU_ADD);
        dec_c.reg_write   = 1'b1;
        dec_c.dmem_to_reg = 2'b01;
      end
      OPC_JAL: begin
        dec_c.alusrc1     = 1'b1;
        dec_c.alusrc2     = 1'b1;
        dec_c.jump        = 1'b1;
        dec_c.reg_write   = 1'b1;
        dec_c.dmem_to_reg = 2'b10;
      end
      OPC_JALR: begin
        dec_c.alusrc2     = 1'b1;
        dec_c.jump        = 1'b1;
        dec_c.reg_write   = 1'b1;
        dec_c.dmem_to_reg = 2'b10;
        dec_c.funct3      = funct3;
        use_rs1_c         = 1'b1;
        illegal_c         = (funct3[2:1] == 2'b01);
      end
      OPC_BRANCH: begin
        dec_c.branch = 1'b1;
        dec_c.funct3 = funct3;
        use_rs1_c    = 1'b1;
        use_rs2_c    = 1'b1;
        case (funct3[2:1])
          2'b00:   dec_c.alu_op = ALU_OP_W'(ALU_SUB);
          2'b10:   dec_c.alu_op = ALU_OP_W'(ALU_SLT);
          2'b11:   dec_c.alu_op = ALU_OP_W'(ALU_SLTU);
          default: illegal_c    = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_c.alusrc2   = 1'b1;
        dec_c.mem_read  = 1'b1;
        dec_c.reg_write = 1'b1;
        dec_c.funct3    = funct3;
        use_rs1_c       = 1'b1;
      end
      OPC_STORE: begin
        dec_c.alusrc2   = 1'b1;
        dec_c.mem_write = 1'b1;
        dec_c.funct3    = funct3;
        use_rs1_c       = 1'b1;
        use_rs2_c       = 1'b1;
      end
      OPC_OPIMM: begin
        dec_c.alusrc2     = 1'b1;
        dec_c.reg_write   = 1'b1;
        dec_c.dmem_to_reg = 2'b01;
        dec_c.funct3      = funct3;
        use_rs1_c         = 1'b1;
        dec_c.alu_op      = (funct3 == 3'd5 && instruction_i[30]) ?
                            ALU_OP_W'(ALU_SRA) : ALU_OP_W'(funct3);
        illegal_c         = (funct3 == 3'd1 || funct3 == 3'd5) && bad_funct7;
      end
      OPC_OP: begin
        dec_c.reg_write   = 1'b1;
        dec_c.dmem_to_reg = 2'b01;
        dec_c.funct3      = funct3;
        use_rs1_c         = 1'b1;
        use_rs2_c         = 1'b1;
        if (funct3 == 3'd0 && instruction_i[30])
          dec_c.alu_op = ALU_OP_W'(ALU_SUB);
        else if (funct3 == 3'd5 && instruction_i[30])
          dec_c.alu_op = ALU_OP_W'(ALU_SRA);
        else
          dec_c.alu_op = ALU_OP_W'(funct3);
        illegal_c = bad_funct7;
      end
      default: illegal_c = 1'b1;
    endcase

    dec_c.rd = REG_ADDR_W'(instruction_i[11:7]);
    if (dec_c.rd == '0) dec_c.reg_write = 1'b0;
`ifdef CONTROL_PIPE_ILLEGAL_EN
    if (illegal_c) begin
      dec_c.reg_write = 1'b0;
      dec_c.mem_write = 1'b0;
    end
    dec_c.illegal = illegal_c;
`endif
    // rd only travels with a real register write
    if (!dec_c.reg_write) dec_c.rd = '0;
  end

`ifndef CONTROL_PIPE_ILLEGAL_EN
  logic illegal_unused;
  assign illegal_unused = illegal_c;
`endif

  // Load in EX whose destination is read by the ID instruction
  assign hazard_c = id_valid_i & ex_valid_q & ex_q.mem_read & (ex_q.rd != '0) &
                    (((ex_q.rd == rs1) & use_rs1_c) | ((ex_q.rd == rs2) & use_rs2_c)) &
                    ~stall_i & ~flush_i;

  // Stage advance: stall > flush > load-use bubble > normal shift
  always_comb begin
    ex_d        = ex_q;
    ex_valid_d  = ex_valid_q;
    mem_d       = mem_q;
    mem_valid_d = mem_valid_q;
    wb_d        = wb_q;
    wb_valid_d  = wb_valid_q;
    if (stall_i) begin
      if (flush_i) ex_valid_d = 1'b0;
    end else begin
      mem_d.mem_read    = ex_q.mem_read;
      mem_d.mem_write   = ex_q.mem_write;
      mem_d.funct3      = ex_q.funct3;
      mem_d.reg_write   = ex_q.reg_write;
      mem_d.dmem_to_reg = ex_q.dmem_to_reg;
      mem_d.rd          = ex_q.rd;
      mem_valid_d       = ex_valid_q;
      wb_d.reg_write    = mem_q.reg_write;
      wb_d.dmem_to_reg  = mem_q.dmem_to_reg;
      wb_d.rd           = mem_q.rd;
      wb_valid_d        = mem_valid_q;
      if (flush_i || hazard_c) begin
        ex_d       = '0;
        ex_valid_d = 1'b0;
      end else begin
        ex_d       = dec_c;
        ex_valid_d = id_valid_i;
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      mem_q       <= '0;
      mem_valid_q <= 1'b0;
      wb_q        <= '0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      mem_q       <= mem_d;
      mem_valid_q <= mem_valid_d;
      wb_q        <= wb_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  // Side-effect controls are gated by their stage valid
  assign hazard_stall_o   = hazard_c;
  assign ex_valid_o       = ex_valid_q;
  assign ex_alusrc1_o     = ex_q.alusrc1;
  assign ex_alusrc2_o     = ex_q.alusrc2;
  assign ex_alu_op_o      = ex_q.alu_op;
  assign ex_branch_o      = ex_valid_q & ex_q.branch;
  assign ex_jump_o        = ex_valid_q & ex_q.jump;
  assign ex_funct3_o      = ex_q.funct3;
  assign mem_valid_o      = mem_valid_q;
  assign mem_read_o       = mem_valid_q & mem_q.mem_read;
  assign mem_write_o      = mem_valid_q & mem_q.mem_write;
  assign mem_funct3_o     = mem_q.funct3;
  assign wb_valid_o       = wb_valid_q;
  assign wb_reg_write_o   = wb_valid_q & wb_q.reg_write;
  assign wb_dmem_to_reg_o = wb_q.dmem_to_reg;
  assign wb_rd_o          = wb_q.rd;
`ifdef CONTROL_PIPE_ILLEGAL_EN
  assign ex_illegal_o     = ex_valid_q & ex_q.illegal;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: randomized instruction stream with a
// spec-level reference decoder and a scoreboard of per-stage expectations.
module tb_control_pipe;
  localparam int unsigned ALU_OP_W   = 6;
  localparam int unsigned REG_ADDR_W = 5;
`ifdef CONTROL_PIPE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JAL = 7'h6F, O_JALR = 7'h67;
  localparam logic [6:0] O_BR = 7'h63, O_LD = 7'h03, O_ST = 7'h23, O_IMM = 7'h13, O_OP = 7'h33;

  logic clk = 1'b0;
  logic reset, id_valid, stall, flush;
  logic [31:0] instruction;
  logic hazard_stall_o, ex_valid_o, ex_alusrc1_o, ex_alusrc2_o, ex_branch_o, ex_jump_o;
  logic [ALU_OP_W-1:0] ex_alu_op_o;
  logic [2:0] ex_funct3_o, mem_funct3_o;
  logic mem_valid_o, mem_read_o, mem_write_o, wb_valid_o, wb_reg_write_o;
  logic [1:0] wb_dmem_to_reg_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic ex_illegal;

  always #5 clk = ~clk;

  control_pipe #(.ALU_OP_W(ALU_OP_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk_i(clk), .reset_i(reset), .instruction_i(instruction), .id_valid_i(id_valid),
    .stall_i(stall), .flush_i(flush), .hazard_stall_o(hazard_stall_o),
    .ex_valid_o(ex_valid_o), .ex_alusrc1_o(ex_alusrc1_o), .ex_alusrc2_o(ex_alusrc2_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
    .ex_funct3_o(ex_funct3_o), .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_funct3_o(mem_funct3_o), .wb_valid_o(wb_valid_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_dmem_to_reg_o(wb_dmem_to_reg_o), .wb_rd_o(wb_rd_o)
`ifdef CONTROL_PIPE_ILLEGAL_EN
    , .ex_illegal_o(ex_illegal)
`endif
  );
`ifndef CONTROL_PIPE_ILLEGAL_EN
  assign ex_illegal = 1'b0;
`endif

  typedef struct {
    logic src1, src2;
    logic [5:0] op;
    logic br, jmp;
    logic [2:0] f3;
    logic mrd, mwr, rw;
    logic [1:0] d2r;
    logic [4:0] rd;
    logic ill;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t ex_q[$], mem_q[$], wb_q[$];
  exp_t mex;
  logic mex_valid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set tables
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    logic [5:0] br_op [8] = '{6'd9, 6'd9, 6'd15, 6'd15, 6'd2, 6'd2, 6'd3, 6'd3};
    logic f7_bad = (f7 != 7'h00) && (f7 != 7'h20);
    e = '{default: 0};
    e.op = 6'd15;
    case (op)
      O_LUI:   begin e.rw = 1'b1; e.d2r = 2'd3; end
      O_AUIPC: begin e.src1 = 1'b1; e.src2 = 1'b1; e.op = 6'd0; e.rw = 1'b1; e.d2r = 2'd1; end
      O_JAL:   begin e.src1 = 1'b1; e.src2 = 1'b1; e.jmp = 1'b1; e.rw = 1'b1; e.d2r = 2'd2; end
      O_JALR:  begin e.src2 = 1'b1; e.jmp = 1'b1; e.rw = 1'b1; e.d2r = 2'd2; e.f3 = f3;
                     e.ill = (f3 == 3'd2 || f3 == 3'd3); end
      O_BR:    begin e.br = 1'b1; e.f3 = f3; e.op = br_op[f3]; e.ill = (f3 == 3'd2 || f3 == 3'd3); end
      O_LD:    begin e.src2 = 1'b1; e.mrd = 1'b1; e.rw = 1'b1; e.d2r = 2'd0; e.f3 = f3; end
      O_ST:    begin e.src2 = 1'b1; e.mwr = 1'b1; e.f3 = f3; end
      O_IMM:   begin
        e.src2 = 1'b1; e.rw = 1'b1; e.d2r = 2'd1; e.f3 = f3;
        e.op = (f3 == 3'd5 && ins[30]) ? 6'd8 : {3'b000, f3};
        e.ill = (f3 == 3'd1 || f3 == 3'd5) && f7_bad;
      end
      O_OP:    begin
        e.rw = 1'b1; e.d2r = 2'd1; e.f3 = f3;
        e.op = {3'b000, f3};
        if (ins[30] && f3 == 3'd0) e.op = 6'd9;
        if (ins[30] && f3 == 3'd5) e.op = 6'd8;
        e.ill = f7_bad;
      end
      default: e.ill = 1'b1;
    endcase
    if (ins[11:7] == 5'd0) e.rw = 1'b0;
    if (ILL_EN && e.ill) begin e.rw = 1'b0; e.mwr = 1'b0; end
    e.rd = e.rw ? ins[11:7] : 5'd0;
    return e;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {O_OP, O_IMM, O_LD, O_ST, O_BR, O_JALR};
  endfunction
  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {O_OP, O_ST, O_BR};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_IMM, O_OP};
    int k = int'($urandom_range(0, 11));
    logic [6:0] op;
    logic [6:0] f7;
    op = (k >= 9) ? ((k == 9) ? 7'($urandom) : O_LD) : ops[k];
    if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
    else f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), op};
  endfunction

  // One clock of stimulus; expected responses are queued before the edge
  task automatic cycle(input logic [31:0] ins, input logic idv, input logic st,
                       input logic fl, input logic rs, output logic hz_dut, output logic hz_exp);
    exp_t d;
    @(negedge clk);
    instruction = ins; id_valid = idv; stall = st; flush = fl; reset = rs;
    #1;
    hz_exp = idv && mex_valid && mex.mrd && (mex.rd != 5'd0) && !st && !fl &&
             ((mex.rd == ins[19:15] && reads_rs1(ins[6:0])) ||
              (mex.rd == ins[24:20] && reads_rs2(ins[6:0])));
    hz_dut = hazard_stall_o;
    chk("hazard_stall", 64'(hz_dut), 64'(hz_exp));
    if (rs) begin
      mex_valid = 1'b0;
      ex_q.delete(); mem_q.delete(); wb_q.delete();
    end else if (st) begin
      if (fl && mex_valid) begin
        mex_valid = 1'b0;
        mem_q.delete(mem_q.size() - 1);
        wb_q.delete(wb_q.size() - 1);
      end
    end else if (fl || hz_exp) begin
      mex_valid = 1'b0;
    end else begin
      d = ref_decode(ins);
      mex = d;
      mex_valid = idv;
      if (idv) begin
        ex_q.push_back(d); mem_q.push_back(d); wb_q.push_back(d);
      end
    end
  endtask

  logic [10:0] ex_core_w;
  logic [3:0]  ex_ctl_w;
  logic [14:0] mw_w;
  assign ex_core_w = {ex_alusrc1_o, ex_alusrc2_o, ex_alu_op_o, ex_funct3_o};
  assign ex_ctl_w  = {ex_valid_o, ex_branch_o, ex_jump_o, ex_illegal};
  assign mw_w      = {mem_valid_o, mem_read_o, mem_write_o, mem_funct3_o,
                      wb_valid_o, wb_reg_write_o, wb_dmem_to_reg_o, wb_rd_o};

  // Monitor: pops the scoreboard whenever a stage presents a valid bundle
  initial begin : monitor
    logic rs, st, fl;
    logic [10:0] p_core;
    logic [3:0]  p_ctl;
    logic [14:0] p_mw;
    exp_t e;
    p_core = '0; p_ctl = '0; p_mw = '0;
    forever begin
      @(posedge clk);
      rs = reset; st = stall; fl = flush;
      #1;
      if (rs) begin
        chk("reset_zero", 64'({ex_core_w, ex_ctl_w, mw_w, hazard_stall_o}), 64'd0);
      end else if (st) begin
        chk("stall_hold", 64'({ex_core_w, mw_w}), 64'({p_core, p_mw}));
        chk("stall_ctl", 64'(ex_ctl_w), fl ? 64'd0 : 64'(p_ctl));
      end else begin
        chk("ex_valid", 64'(ex_valid_o), 64'(ex_q.size() != 0));
        if (ex_valid_o && ex_q.size() != 0) begin
          e = ex_q.pop_front();
          chk("ex_bundle", 64'({ex_core_w, ex_branch_o, ex_jump_o, ex_illegal}),
              64'({e.src1, e.src2, e.op, e.f3, e.br, e.jmp, e.ill & ILL_EN}));
        end else if (!ex_valid_o) begin
          chk("ex_bubble", 64'({ex_branch_o, ex_jump_o, ex_illegal}), 64'd0);
        end
        if (mem_valid_o) begin
          if (mem_q.size() == 0) chk("mem_unexpected", 64'd1, 64'd0);
          else begin
            e = mem_q.pop_front();
            chk("mem_bundle", 64'({mem_read_o, mem_write_o, mem_funct3_o}),
                64'({e.mrd, e.mwr, e.f3}));
          end
        end else chk("mem_bubble", 64'({mem_read_o, mem_write_o}), 64'd0);
        if (wb_valid_o) begin
          if (wb_q.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
          else begin
            e = wb_q.pop_front();
            chk("wb_bundle", 64'({wb_reg_write_o, wb_dmem_to_reg_o, wb_rd_o}),
                64'({e.rw, e.d2r, e.rd}));
          end
        end else chk("wb_bubble", 64'(wb_reg_write_o), 64'd0);
      end
      p_core = ex_core_w; p_ctl = ex_ctl_w; p_mw = mw_w;
    end
  end

  initial begin : driver
    logic hzd, hze, idv, st, fl, rs, held;
    logic [31:0] cur;
    reset = 1'b1; id_valid = 1'b0; stall = 1'b0; flush = 1'b0; instruction = '0;
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, hzd, hze);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, hzd, hze);

    // add then sub
    cycle(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    cycle(32'h402081B3, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    @(posedge clk); #2;
    chk("sub_alu_op", 64'(ex_alu_op_o), 64'd9);

    // reset mid-stream, then first instruction after release
    cycle(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b1, hzd, hze);
    cycle(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b1, hzd, hze);
    cycle(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    @(posedge clk); #2;
    chk("post_reset_ex_valid", 64'(ex_valid_o), 64'd1);

    // load-use: one stall cycle, then the add enters EX
    cycle(32'h0000A283, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    cycle(32'h00128333, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    chk("load_use_stall", 64'(hzd), 64'd1);
    cycle(32'h00128333, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    chk("load_use_once", 64'(hzd), 64'd0);
    @(posedge clk); #2;
    chk("load_use_add_op", 64'({ex_valid_o, ex_alu_op_o}), 64'({1'b1, 6'd0}));

    // no false hazards: load to x0, or consumer reading only x7
    cycle(32'h0000A003, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    cycle(32'h00000333, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    chk("no_hazard_x0", 64'(hzd), 64'd0);
    cycle(32'h0000A283, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    cycle(32'h00738333, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    chk("no_hazard_x7", 64'(hzd), 64'd0);

    // beq in EX resolved taken, then a 3-cycle stall
    cycle(32'h00208463, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    cycle(32'h002081B3, 1'b1, 1'b0, 1'b1, 1'b0, hzd, hze);
    @(posedge clk); #2;
    chk("flush_bubble", 64'({ex_valid_o, mem_valid_o}), 64'b01);
    repeat (3) cycle(32'h002081B3, 1'b1, 1'b1, 1'b0, 1'b0, hzd, hze);

    // all-zero word is an unknown opcode
    cycle(32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, hzd, hze);
    @(posedge clk); #2;
    chk("unknown_op", 64'({ex_alu_op_o, ex_illegal}), 64'({6'd15, ILL_EN}));

    // randomized stream; upstream holds its instruction on stall or hazard
    held = 1'b0; cur = '0; idv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!held) begin
        cur = rand_instr();
        idv = ($urandom_range(0, 9) != 0);
      end
      rs = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0);
      cycle(cur, idv, st, fl, rs, hzd, hze);
      held = !rs && (st || hze);
    end

    repeat (6) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, hzd, hze);
    @(posedge clk); #2;
    chk("drain_empty", 64'(ex_q.size() + mem_q.size() + wb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
Parametrised successor to the single-cycle control decoder. It decodes the RV32I instruction in ID and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB control stages.
- Adds a valid bit per stage, stall/flush handling and load-use hazard detection.
- Sits between the IF/ID register and the datapath; datapath stage registers consume its per-stage outputs.

Parameters:
ALU_OP_W, 6, ALU op field width (min 4); zero-extended encoding.
REG_ADDR_W, 5, register index width.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
instruction_i  in  32  instruction in ID
id_valid_i  in  1  instruction_i is a real instruction
stall_i  in  1  global freeze (e.g. memory wait)
flush_i  in  1  branch/jump resolved taken in EX; kill the ID instruction
hazard_stall_o  out  1  load-use stall request to PC/IF-ID
ex_valid_o  out  1  ID/EX valid
ex_alusrc1_o  out  1  1:pc, 0:rs1
ex_alusrc2_o  out  1  1:imm, 0:rs2
ex_alu_op_o  out  ALU_OP_W  ALU op
ex_branch_o  out  1  conditional branch
ex_jump_o  out  1  JAL/JALR
ex_funct3_o  out  3  funct3
mem_valid_o  out  1  EX/MEM valid
mem_read_o  out  1  load
mem_write_o  out  1  store
mem_funct3_o  out  3  access size/sign
wb_valid_o  out  1  MEM/WB valid
wb_reg_write_o  out  1  write enable
wb_dmem_to_reg_o  out  2  00:mem, 01:alu, 10:pc+4, 11:imm
wb_rd_o  out  REG_ADDR_W  destination register

Behaviour:
- Decode is combinational on instruction_i; ALU codes:
  - ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7, SRA 8, SUB 9, PASS/NOP 15.
  - R/I types use funct3; bit30 selects SUB (R only) and SRA/SRAI.
  - BEQ/BNE -> 9; BLT/BGE -> 2; BLTU/BGEU -> 3.
  - LUI/JAL/JALR/load/store -> 15; AUIPC -> 0.
- Decode fields per opcode:
  - LUI: dmem_to_reg 11.
  - AUIPC: alusrc1=1, alusrc2=1, dmem_to_reg 01.
  - JAL: alusrc1=1, alusrc2=1, jump, dmem_to_reg 10.
  - JALR: alusrc2=1, jump, dmem_to_reg 10.
  - Loads: alusrc2=1, mem_read, dmem_to_reg 00.
  - Stores: alusrc2=1, mem_write.
  - Unknown opcode: all zero, op 15, no write.
- reg_write is forced 0 when rd==0.
- Reset: all outputs 0 at the next clock edge, including all valids and hazard_stall_o.
  - ex_alu_op_o resets to 0, not 15; consumers gate on valid.
  - Reset mid-operation discards all in-flight bundles.
- Latency: bundle sampled at edge N appears on ex_* at N+1, mem_* at N+2, wb_* at N+3.
- Load-use hazard (combinational):
  - hazard_stall_o = id_valid_i & ex_valid_o & ex-stage mem_read & ex_rd!=0 & match.
  - Match: (ex_rd==rs1 and the ID instruction uses rs1) or (ex_rd==rs2 and it uses rs2).
  - rs1 users: R, I, load, store, branch, JALR. rs2 users: R, store, branch.
- Per-edge priority:
  1. reset_i: all stages cleared.
  2. stall_i: all three stages hold. If flush_i is also high, ID/EX valid is cleared while the stage otherwise holds.
  3. flush_i: ID/EX loads a bubble (valid=0, all controls 0); EX/MEM and MEM/WB advance.
  4. hazard_stall_o: ID/EX loads a bubble; later stages advance. The upstream holds the instruction, which is re-decoded next cycle; the hazard clears since the load has moved to MEM.
  5. Normal: ID/EX loads the decode with valid=id_valid_i; other stages shift.
- Bubble rule: any stage with valid=0 drives reg_write, mem_read, mem_write, branch and jump outputs as 0.
- hazard_stall_o is suppressed (0) while stall_i or flush_i is high.

Optional Feature:
CONTROL_PIPE_ILLEGAL_EN
- With: adds port ex_illegal_o (1 bit), registered with ID/EX.
- It is set for an unknown opcode, funct3 2/3 on JALR or branch, or funct7 other than 0000000/0100000 on R-type or shift-immediate.
- An illegal instruction gets reg_write=0 and mem_write=0.
- Without: the port is absent; unknown opcodes decode silently as a NOP bundle.

Test Plan:
- Reset: reset_i=1 for 2 cycles mid-stream -> every output 0 on the next edge; the first valid instruction after release reaches ex_valid_o exactly 1 cycle later.
- Pipeline: 0x002081B3 (add x3,x1,x2) then 0x402081B3 (sub x3,x1,x2), id_valid_i=1 -> ex_alu_op_o 0 then 9. The add appears at wb_* 2 cycles after ex_* with wb_reg_write_o=1, wb_rd_o=3, wb_dmem_to_reg_o=01.
- Load-use: 0x0000A283 (lw x5,0(x1)) then 0x00128333 (add x6,x5,x1) -> hazard_stall_o=1 for exactly 1 cycle and an ex_valid_o=0 bubble; the add reaches EX with op 0 one cycle later.
- No false hazard: lw x5 followed by an instruction writing x0 or reading only x7 -> hazard_stall_o stays 0.
- Flush/stall: 0x00208463 (beq) in EX with flush_i=1 -> the next ex_valid_o=0 and mem_valid_o=1 (beq advances). stall_i=1 for 3 cycles -> all stage outputs unchanged.
- Illegal, macro on: 0x00000000 -> ex_illegal_o=1, wb_reg_write_o=0. Macro off -> NOP bundle, ex_alu_op_o=15.
